serial_adder_nand: RTL and testbench
====================================

Name: serial_adder_nand

Overview:
Bit-serial N-bit adder that performs the forward operation to the team's NAND-only full subtractor.
- Operands are captured on a start pulse and added LSB-first, one bit per clock.
- Each bit passes through a single NAND-only full-adder cell, with the carry held in a flip-flop between bits.
- A start/busy/done handshake frames each operation.
- Intended as the area-minimal adder in the gate-level arithmetic set.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 2..32)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  request pulse; sampled only when not busy
a  in  WIDTH  operand A, sampled on accepted start
b  in  WIDTH  operand B, sampled on accepted start
cin  in  1  carry-in, sampled on accepted start
busy  out  1  high while bits are being processed
done  out  1  one-cycle pulse when sum/cout become valid
sum  out  WIDTH  registered result (a+b+cin) mod 2^WIDTH
cout  out  1  registered carry-out of the MSB

Behaviour:
- Reset is asynchronous, active-high. Outputs on reset: busy=0, done=0, sum=0, cout=0. Internal state on reset: state=IDLE, carry=0, bit counter=0, shift registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - load a and b into shift registers; carry<=cin; count<=0.
  - go to RUN; busy=1 from the next cycle.
- RUN, each cycle:
  - the full-adder cell computes s=a_sr[0]^b_sr[0]^carry and co=maj(a_sr[0],b_sr[0],carry).
  - carry<=co.
  - sum shift register shifts right, with s inserted at the MSB.
  - a_sr and b_sr shift right.
  - count increments.
- RUN exit: when count==WIDTH-1, the shift completes and the FSM goes to DONE.
- Result capture: on the RUN->DONE edge, sum<=final sum shift register and cout<=final carry. These registers are unchanged at all other times except reset.
- DONE: done=1 and busy=0 for exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation), going to RUN.
  - otherwise the FSM returns to IDLE.
- Latency: start accepted at edge T gives done=1 in the cycle after edge T+WIDTH. That is WIDTH+1 cycles from the start edge to the done cycle; throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored. Operands and carry are not disturbed.
- a, b and cin are don't-care except on the accepted start edge.
- Overflow: WIDTH-bit wrap-around; the lost MSB carry appears only on cout. The adder is unsigned; no signed overflow flag.
- Reset asserted mid-operation:
  - the operation is aborted and done never pulses for it.
  - all outputs return to reset values immediately (asynchronously).
  - after rst deasserts, the first start is accepted normally.
- Arithmetic is only through the NAND-only full-adder cell. No behavioural '+' in RTL.

Decomposition:
- Shared package serial_arith_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - default WIDTH constant.
- One sub-module: fa_cell_nand (inputs x, y, ci; outputs s, co).
  - Built from 9 two-input NAND primitives.
  - Instantiated once in the datapath.
- Counter width is $clog2(WIDTH).

Test Plan:
- WIDTH=8; a=0x5A, b=0x3C, cin=0; start pulsed at cycle 0 -> done pulses in cycle 9, sum=0x96, cout=0; busy high in cycles 1..8.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Exhaustive WIDTH=4 sweep over all a, b, cin (512 cases) -> {cout,sum}==a+b+cin for each case, with done exactly once per start.
- start re-pulsed with different operands in cycles 3 and 5 of a run -> ignored; result is that of the original operands; no extra done.
- rst asserted in cycle 4 of a run -> busy, done, sum and cout go to 0 immediately. New start after release gives a correct result (0x10+0x20 -> 0x30).
- start held high continuously -> operations are accepted in each DONE cycle back-to-back; done pulses every 9 cycles; operands are resampled each time.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// ---------------------------------------------------------------------------
// serial_arith_pkg
// Shared definitions for the bit-serial gate-level arithmetic blocks:
//   - FSM state encoding used by the serial adder/subtractor controllers
//   - default operand width
//   - a gate-level ripple incrementer for the bit counters, so that no
//     behavioural '+' appears anywhere in the arithmetic set
// ---------------------------------------------------------------------------
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Ripple incrementer built from XOR/AND: bit i toggles when all lower
    // bits are one. Callers truncate the result to their counter width.
    function automatic logic [31:0] incr32(input logic [31:0] x);
        logic [31:0] r;
        logic        c;
        r = '0;
        c = 1'b1;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[i] ^ c;
            c    = c & x[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fa_cell_nand.sv
// ---------------------------------------------------------------------------
// fa_cell_nand
// One-bit full adder built from nine two-input NAND gates.
// Ports:
//   x, y  in   operand bits
//   ci    in   carry in
//   s     out  sum bit      = x ^ y ^ ci
//   co    out  carry out    = maj(x, y, ci)
// ---------------------------------------------------------------------------
module fa_cell_nand (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic n1, n2, n3, h, n5, n6, n7;

    // First half adder: h = x ^ y, n1 = ~(x & y)
    nand g1 (n1, x,  y);
    nand g2 (n2, x,  n1);
    nand g3 (n3, y,  n1);
    nand g4 (h,  n2, n3);

    // Second half adder: s = h ^ ci, n5 = ~(h & ci)
    nand g5 (n5, h,  ci);
    nand g6 (n6, h,  n5);
    nand g7 (n7, ci, n5);
    nand g8 (s,  n6, n7);

    // co = (x & y) | (h & ci), both terms already available inverted
    nand g9 (co, n5, n1);

endmodule

// File: rtl/serial_adder_nand.sv
// ---------------------------------------------------------------------------
// serial_adder_nand
// Bit-serial unsigned adder: operands are captured on start and added LSB
// first through a single NAND-only full-adder cell, one bit per clock, with
// the carry held in a flop between bits. Result is (a + b + cin) mod 2^WIDTH
// plus the carry out of the MSB.
//
// State table:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; result registers hold the last answer
//   ST_RUN  | one bit per cycle through the full-adder cell, busy=1
//   ST_DONE | done=1 for one cycle; a start here is accepted immediately
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   request pulse, sampled only when not busy
//   a, b   in   WIDTH-bit operands, sampled on accepted start
//   cin    in   carry in, sampled on accepted start
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when sum/cout become valid
//   sum    out  registered WIDTH-bit result
//   cout   out  registered carry out of the MSB
// ---------------------------------------------------------------------------
module serial_adder_nand
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   a_sr_q,   a_sr_d;
    logic [WIDTH-1:0]   b_sr_q,   b_sr_d;
    logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
    logic               carry_q,  carry_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic [WIDTH-1:0]   sum_q,    sum_d;
    logic               cout_q,   cout_d;

    logic fa_s;
    logic fa_co;

    fa_cell_nand u_fa (
        .x  (a_sr_q[0]),
        .y  (b_sr_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        count_d  = count_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sum_d    = sum_q;
        cout_d   = cout_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    sum_sr_d = '0;
                    carry_d  = cin;
                    count_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end

            ST_RUN: begin
                // Sum bits enter at the MSB so that after WIDTH shifts the
                // first (LSB) result bit has reached position 0.
                carry_d  = fa_co;
                sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                count_d  = CNT_W'(incr32(32'(count_q)));
                if (count_q == LAST_BIT) begin
                    sum_d   = sum_sr_d;
                    cout_d  = fa_co;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_nand.sv
module tb_serial_adder_nand;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, cin;
    logic [7:0] a, b, sum;
    logic       busy, done, cout;

    logic       start4, cin4;
    logic [3:0] a4, b4, sum4;
    logic       busy4, done4, cout4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder_nand #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder_nand #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 9-bit addition.
    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {8'd0, c};
    endfunction

    // One full operation on the 8-bit DUT, starting from IDLE.
    task automatic run_op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                           input logic [7:0] exp_s, input logic exp_c, input string name);
        int n;
        int busy_cnt;
        start = 1'b1; a = ia; b = ib; cin = ic;
        tick();
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        n = 0; busy_cnt = 0;
        while (!done && n < 30) begin
            if (busy) busy_cnt++;
            tick();
            n++;
        end
        chk({name, " latency"}, n, 8);
        chk({name, " busy cycles"}, busy_cnt, 8);
        chk({name, " sum"}, sum, exp_s);
        chk({name, " cout"}, cout, exp_c);
        tick();
        chk({name, " done one cycle"}, done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global timeout: simulation did not finish, expected finish before 1ms");
        $fatal(1, "timeout");
    end

    initial begin
        logic [8:0] m;
        logic [7:0] opa[28];
        logic [7:0] opb[28];
        logic       opc[28];
        int         dones;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

        rst = 1'b1;
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        #3;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset sum", sum, 0);
        chk("reset cout", cout, 0);
        chk("reset w4 outputs", {busy4, done4, cout4, sum4}, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Directed vectors
        for (int i = 0; i < 7; i++)
            run_op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout,
                    $sformatf("vec%0d", i));

        // Exhaustive WIDTH=4 sweep
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    int n;
                    logic [4:0] exp5;
                    exp5 = 5'(ia) + 5'(ib) + 5'(ic);
                    start4 = 1'b1; a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic);
                    tick();
                    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
                    n = 0;
                    while (!done4 && n < 20) begin
                        tick();
                        n++;
                    end
                    chk($sformatf("w4 %0d+%0d+%0d latency", ia, ib, ic), n, 4);
                    chk($sformatf("w4 %0d+%0d+%0d result", ia, ib, ic), {cout4, sum4}, exp5);
                    tick();
                    chk($sformatf("w4 %0d+%0d+%0d single done", ia, ib, ic), done4, 0);
                end
            end
        end

        // start re-pulsed during a run is ignored
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        tick();
        start = 1'b0;
        dones = 0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (cyc == 3 || cyc == 5) begin
                start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) dones++;
            chk($sformatf("ignore busy c%0d", cyc + 1), busy, (cyc + 1 <= 8) ? 1 : 0);
            if (cyc + 1 == 9) begin
                chk("ignore done", done, 1);
                chk("ignore sum", sum, 8'h46);
                chk("ignore cout", cout, 0);
            end
        end
        start = 1'b0;
        chk("ignore done count", dones, 1);

        // Reset in the middle of a run
        start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("midrst busy before", busy, 1);
        chk("midrst sum before", sum, 8'h46);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst sum", sum, 0);
        chk("midrst cout", cout, 0);
        tick();
        #2;
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) dones++;
        end
        chk("midrst no done after abort", dones, 0);
        run_op8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "after reset");

        // start held high: back-to-back operation
        for (int i = 0; i < 28; i++) begin
            opa[i] = 8'($urandom);
            opb[i] = 8'($urandom);
            opc[i] = 1'($urandom);
        end
        for (int c = 0; c < 27; c++) begin
            start = 1'b1; a = opa[c]; b = opb[c]; cin = opc[c];
            tick();
            chk($sformatf("b2b done c%0d", c + 1), done, ((c + 1) % 9 == 0) ? 1 : 0);
            if ((c + 1) % 9 == 0) begin
                m = model8(opa[c + 1 - 9], opb[c + 1 - 9], opc[c + 1 - 9]);
                chk($sformatf("b2b result c%0d", c + 1), {cout, sum}, m);
            end
        end
        start = 1'b0;
        tick();
        tick();
        chk("b2b idle after release", busy, 0);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            logic       rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            m = model8(ra, rb, rc);
            run_op8(ra, rb, rc, m[7:0], m[8], $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
